// File: rtl/carry_lookahead_adder_4b.sv
// carry_lookahead_adder_4b: 4-bit carry-lookahead adder with registered sum, carry and group P/G
module carry_lookahead_adder_4b (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out,
  output logic       grp_p,
  output logic       grp_g
);
  logic [3:0] w_p, w_g, w_sum;
  logic [4:0] w_c;
  logic       w_gp, w_gg;
  logic [3:0] r_s;
  logic       r_c_out, r_grp_p, r_grp_g;
  assign w_p = a ^ b;
  assign w_g = a & b;
  assign w_c[0] = c_in;
  assign w_c[1] = w_g[0] | (w_p[0] & c_in);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_in);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & c_in);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & c_in);
  assign w_gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign w_gp = &w_p;
  assign w_sum = w_p ^ w_c[3:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s     <= 4'b0000;
      r_c_out <= 1'b0;
      r_grp_p <= 1'b0;
      r_grp_g <= 1'b0;
    end else begin
      r_s     <= w_sum;
      r_c_out <= w_c[4];
      r_grp_p <= w_gp;
      r_grp_g <= w_gg;
    end
  end
  assign s     = r_s;
  assign c_out = r_c_out;
  assign grp_p = r_grp_p;
  assign grp_g = r_grp_g;
endmodule

// File: tb/tb_carry_lookahead_adder_4b.sv
// tb_carry_lookahead_adder_4b: randomized and exhaustive scoreboard bench for the 4-bit CLA
module tb_carry_lookahead_adder_4b;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = 4'd0, b = 4'd0;
  logic       c_in = 1'b0;
  logic [3:0] s;
  logic       c_out, grp_p, grp_g;

  typedef struct {
    logic       rst;
    logic       ci;
    logic [3:0] s;
    logic       co;
    logic       gp;
    logic       gg;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  carry_lookahead_adder_4b dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c_in(c_in),
    .s(s), .c_out(c_out), .grp_p(grp_p), .grp_g(grp_g)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic; group terms from the 4-bit sum without carry-in
  task automatic apply(input logic r, input logic [3:0] ta, input logic [3:0] tb, input logic tc);
    exp_t e;
    int   sum, ab;
    @(negedge clk);
    rst = r; a = ta; b = tb; c_in = tc;
    sum = int'(ta) + int'(tb) + int'(tc);
    ab  = int'(ta) + int'(tb);
    e.rst = r;
    e.ci  = tc;
    e.s   = r ? 4'd0 : 4'(sum % 16);
    e.co  = r ? 1'b0 : (sum >= 16);
    e.gp  = r ? 1'b0 : (ab == 15);
    e.gg  = r ? 1'b0 : (ab >= 16);
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        vectors++;
        if ({s, c_out, grp_p, grp_g} !== {e.s, e.co, e.gp, e.gg}) begin
          miscompares++;
          $display("FAIL result: rst=%0b got s=%b c_out=%b grp_p=%b grp_g=%b, want s=%b c_out=%b grp_p=%b grp_g=%b",
                   e.rst, s, c_out, grp_p, grp_g, e.s, e.co, e.gp, e.gg);
        end
        if (!e.rst && (c_out !== (grp_g | (grp_p & e.ci)))) begin
          miscompares++;
          $display("FAIL invariant: c_out=%b grp_g=%b grp_p=%b c_in=%b", c_out, grp_g, grp_p, e.ci);
        end
      end
    end
  end

  initial begin
    apply(1'b1, 4'hF, 4'hF, 1'b1);
    apply(1'b1, 4'hF, 4'hF, 1'b1);
    apply(1'b0, 4'hF, 4'h0, 1'b0);
    apply(1'b0, 4'h0, 4'hF, 1'b0);
    apply(1'b0, 4'hA, 4'h5, 1'b0);
    apply(1'b0, 4'hF, 4'hF, 1'b0);
    apply(1'b0, 4'hF, 4'hF, 1'b1);
    apply(1'b0, 4'hF, 4'h0, 1'b1);
    apply(1'b0, 4'h0, 4'hF, 1'b1);
    apply(1'b0, 4'h5, 4'hA, 1'b1);
    for (int i = 0; i < 40; i++)
      apply(1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
    apply(1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
    for (int i = 0; i < 40; i++)
      apply(1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
    for (int i = 0; i < 512; i++)
      apply(1'b0, 4'(i >> 5), 4'(i >> 1), 1'(i));
    for (int i = 0; i < 100; i++)
      apply(1'($urandom_range(0, 15) == 0), 4'($urandom), 4'($urandom), 1'($urandom));
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d results never checked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
